// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with any depth >= 2, standard or first-word-fall-through read.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ALMOST_WR = 2,
    parameter int ALMOST_RD = 1,
    parameter int FWFT = 0,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  valid,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CW-1:0]         data_count
);
    localparam int PW = FIFO_DEPTH > 2 ? $clog2(FIFO_DEPTH) : 1;
    if (FIFO_DEPTH < 2 || ALMOST_WR >= FIFO_DEPTH || ALMOST_RD >= FIFO_DEPTH) begin : g_bad
        $error("sync_fifo: illegal FIFO_DEPTH/ALMOST_WR/ALMOST_RD");
    end
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic wr_ok, rd_ok;
    assign full = data_count == CW'(FIFO_DEPTH);
    assign empty = data_count == '0;
    assign almost_full = data_count >= CW'(FIFO_DEPTH - ALMOST_WR);
    assign almost_empty = data_count <= CW'(ALMOST_RD);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            data_count <= '0;
            wr_ack <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            data_count <= data_count + CW'(wr_ok) - CW'(rd_ok);
            wr_ack <= wr_ok;
            overflow <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end
    // Stale memory is masked while empty so discarded words never reach dout.
    if (FWFT != 0) begin : g_fwft
        assign dout = empty ? '0 : mem[rd_ptr];
        assign valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout <= '0;
                valid <= 1'b0;
            end else begin
                valid <= rd_ok;
                if (rd_ok) dout <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model checks of a default FIFO and a depth-6 FWFT FIFO.
module tb_sync_fifo;
    logic clk = 0, rst = 1;
    logic we0 = 0, re0 = 0, we1 = 0, re1 = 0;
    logic [7:0] din0 = 0, din1 = 0, dout0, dout1;
    logic full0, empty0, af0, ae0, ack0, vld0, ovf0, unf0;
    logic full1, empty1, af1, ae1, ack1, vld1, ovf1, unf1;
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    int errors = 0, checks = 0;
    logic [7:0] q [2][$];
    logic [7:0] dm [2];
    bit mvld [2], mack [2], movf [2], munf [2];
    int depth [2] = '{8, 6};
    int alw [2] = '{2, 1};
    int alr [2] = '{1, 2};
    bit fw [2] = '{1'b0, 1'b1};
    always #5 clk = ~clk;
    sync_fifo u0 (.clk(clk), .rst(rst), .wr_en(we0), .din(din0), .rd_en(re0), .dout(dout0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .wr_ack(ack0),
        .valid(vld0), .overflow(ovf0), .underflow(unf0), .data_count(cnt0));
    sync_fifo #(.FIFO_DEPTH(6), .ALMOST_WR(1), .ALMOST_RD(2), .FWFT(1)) u1 (.clk(clk), .rst(rst),
        .wr_en(we1), .din(din1), .rd_en(re1), .dout(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .wr_ack(ack1), .valid(vld1), .overflow(ovf1),
        .underflow(unf1), .data_count(cnt1));

    task automatic chk(int k, string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL u%0d %s: observed %0h expected %0h", k, tag, obs, exp);
        end
    endtask

    task automatic check_all(int k);
        logic [7:0] od;
        logic [3:0] oc;
        logic of, oe, oaf, oae, oack, ov, oovf, ounf;
        int n = q[k].size();
        if (k == 0) begin
            od = dout0; oc = cnt0; of = full0; oe = empty0; oaf = af0; oae = ae0;
            oack = ack0; ov = vld0; oovf = ovf0; ounf = unf0;
        end else begin
            od = dout1; oc = {1'b0, cnt1}; of = full1; oe = empty1; oaf = af1; oae = ae1;
            oack = ack1; ov = vld1; oovf = ovf1; ounf = unf1;
        end
        chk(k, "data_count", oc, n);
        chk(k, "full", of, n == depth[k]);
        chk(k, "empty", oe, n == 0);
        chk(k, "almost_full", oaf, n >= depth[k] - alw[k]);
        chk(k, "almost_empty", oae, n <= alr[k]);
        chk(k, "wr_ack", oack, mack[k]);
        chk(k, "overflow", oovf, movf[k]);
        chk(k, "underflow", ounf, munf[k]);
        chk(k, "valid", ov, fw[k] ? n != 0 : mvld[k]);
        chk(k, "dout", od, fw[k] ? (n != 0 ? q[k][0] : 8'h00) : dm[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            dm[k] = 0; mvld[k] = 0; mack[k] = 0; movf[k] = 0; munf[k] = 0;
        end
    endtask

    task automatic upd(int k, bit we, bit re, logic [7:0] d);
        int n = q[k].size();
        bit f = n == depth[k];
        bit e = n == 0;
        bit wok = we && !f;
        bit rok = re && !e;
        mack[k] = wok; movf[k] = we && f; munf[k] = re && e;
        if (!fw[k]) begin
            mvld[k] = rok;
            if (rok) dm[k] = q[k][0];
        end
        if (rok) void'(q[k].pop_front());
        if (wok) q[k].push_back(d);
    endtask

    task automatic step(bit w0, bit r0, logic [7:0] d0, bit w1, bit r1, logic [7:0] d1);
        we0 = w0; re0 = r0; din0 = d0; we1 = w1; re1 = r1; din1 = d1;
        @(posedge clk);
        upd(0, w0, r0, d0);
        upd(1, w1, r1, d1);
        #1;
        check_all(0);
        check_all(1);
        we0 = 0; re0 = 0; we1 = 0; re1 = 0;
    endtask

    task automatic async_reset();
        #2 rst = 1;
        #1 model_reset();
        check_all(0);
        check_all(1);
        #1 rst = 0;
    endtask

    initial begin
        logic [7:0] seq [10] = '{17, 20, 1, 2, 3, 4, 5, 6, 7, 8};
        model_reset();
        #1 check_all(0);
        check_all(1);
        repeat (2) @(posedge clk);
        #4 rst = 0;
        // Fill past full with reads idle, then drain past empty.
        for (int i = 0; i < 10; i++) step(1, 0, seq[i], 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
        // Simultaneous write+read while full: read wins, write is rejected.
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0, 0, 0);
        step(1, 1, 8'h99, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
        // Depth-6 FWFT: steady count of 3 across pointer wrap.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'($urandom));
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 8'($urandom));
        chk(1, "steady_count", {29'b0, cnt1}, 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 8'hA5);
        chk(1, "fwft_head", dout1, 8'hA5);
        step(0, 0, 0, 0, 1, 0);
        chk(1, "fwft_pop_empty", empty1, 1'b1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, 8'($urandom));
        // Reset mid-operation with both FIFOs partly full.
        for (int i = 0; i < 12 && q[0].size() != 5; i++)
            step(q[0].size() < 5, q[0].size() > 5, 8'($urandom), 1, 0, 8'($urandom));
        chk(0, "pre_reset_count", {28'b0, cnt0}, q[0].size());
        async_reset();
        step(1, 0, 8'h3C, 1, 0, 8'h5A);
        step(1, 1, 8'h7E, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one data word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of entries; any integer >= 2, not restricted to powers of two.
REQ-003 SHALL have parameter ALMOST_WR, default 2, almost_full margin in entries below full.
REQ-004 SHALL have parameter ALMOST_RD, default 1, almost_empty threshold in entries.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL derive CW = clog2(FIFO_DEPTH+1) as the data_count width.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 wr_en  input  1  write request.
REQ-010 din  input  DATA_WIDTH  write data.
REQ-011 rd_en  input  1  read request (standard) / head-word acknowledge (FWFT).
REQ-012 dout  output  DATA_WIDTH  read data.
REQ-013 full, empty  output  1 each  occupancy == FIFO_DEPTH / == 0.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags.
REQ-015 wr_ack  output  1  previous-cycle write accepted.
REQ-016 valid  output  1  dout holds a valid word.
REQ-017 overflow, underflow  output  1 each  rejected-request pulses.
REQ-018 data_count  output  CW  current occupancy.

Function
REQ-019 Write SHALL be accepted iff wr_en=1 and full=0; din stored at wr_ptr, wr_ptr advances.
REQ-020 Read SHALL be accepted iff rd_en=1 and empty=0; rd_ptr advances.
REQ-021 Pointers SHALL wrap from FIFO_DEPTH-1 to 0 for every legal FIFO_DEPTH, including non-power-of-two.
REQ-022 data_count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read or no access.
REQ-023 full/empty/almost flags SHALL decode registered data_count: almost_full = count >= FIFO_DEPTH-ALMOST_WR; almost_empty = count <= ALMOST_RD.
REQ-024 When full, wr_en SHALL be rejected even if a read is accepted in the same cycle; when empty, rd_en SHALL be rejected even if a write is accepted.
REQ-025 wr_ack SHALL pulse high for one cycle, one cycle after each accepted write.
REQ-026 overflow SHALL pulse high for one cycle, one cycle after wr_en=1 with full=1; storage and pointers unchanged.
REQ-027 underflow SHALL pulse high for one cycle, one cycle after rd_en=1 with empty=1; dout holds its value.
REQ-028 FWFT=0: dout SHALL be registered and updated one cycle after an accepted read; valid high for exactly that cycle; dout holds otherwise.
REQ-029 FWFT=1: dout SHALL present mem[rd_ptr] with valid = ~empty; the first word written into an empty FIFO SHALL appear on dout with valid=1 one cycle after its write; rd_en pops it.
REQ-030 Elaboration SHALL fail if FIFO_DEPTH < 2, ALMOST_WR >= FIFO_DEPTH or ALMOST_RD >= FIFO_DEPTH.

Reset
REQ-031 rst=1 SHALL immediately clear pointers and data_count; empty=1, almost_empty=1, full=0, almost_full=0, dout=0, valid=0, wr_ack=0, overflow=0, underflow=0.
REQ-032 Reset mid-operation SHALL discard all stored words; memory contents are not cleared and never become visible.
REQ-033 First access SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Defaults, FWFT=0: write 17,20,1..8 (10 writes) -> first 8 accepted, wr_ack x8, full=1 after 8th, overflow pulses on writes 9,10; data_count=8, almost_full=1 from count 6.
REQ-035 Then 10 reads -> dout 17,20,1,2,3,4,5,6 with valid one cycle after each accepted read, underflow on reads 9,10, empty=1, almost_empty=1 at count <= 1.
REQ-036 FIFO_DEPTH=6: 20 cycles of simultaneous wr_en/rd_en at count 3 -> data_count stays 3, data in order across pointer wrap 5->0.
REQ-037 FWFT=1: write 0xA5 into empty FIFO -> next cycle dout=0xA5, valid=1; rd_en=1 -> valid=0, empty=1 next cycle.
REQ-038 Full FIFO, wr_en and rd_en same cycle -> read accepted, write rejected, overflow=1, data_count 8->7.
REQ-039 rst pulsed asynchronously with count=5 -> all outputs at reset values without clock edge; next write/read returns new data only.
